// File: rtl/ov7670_pkg.sv
// Shared types and ROM control codes for the OV7670 register-init sequencer.
// The ROM stores {register, value} pairs; two reserved words act as commands.
package ov7670_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        LATCH,
        DECODE,
        SEND,
        WAIT,
        DELAY,
        DONE,
        ERR
    } cfg_state_t;

    localparam logic [15:0] ROM_END   = 16'hFFFF;
    localparam logic [15:0] ROM_DELAY = 16'hFFF0;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] value;
    } cfg_entry_t;

endpackage

// File: rtl/ov7670_cfg_seq_if.sv
// Write-request channel between the init sequencer and the SCCB master:
// a valid/ready request carrying {reg, data}, then a done pulse with a NACK flag.
interface ov7670_cfg_seq_if;

    logic       sccb_valid;
    logic       sccb_ready;
    logic [7:0] sccb_reg;
    logic [7:0] sccb_data;
    logic       sccb_done;
    logic       sccb_nack;

    modport master (
        output sccb_valid,
        output sccb_reg,
        output sccb_data,
        input  sccb_ready,
        input  sccb_done,
        input  sccb_nack
    );

    modport slave (
        input  sccb_valid,
        input  sccb_reg,
        input  sccb_data,
        output sccb_ready,
        output sccb_done,
        output sccb_nack
    );

endinterface

// File: rtl/cfg_delay_timer.sv
// Loadable down-counter used for the timed-delay ROM command.
// Loading starts a window of DELAY_CYCLES cycles ending on the cycle zero is first seen.
module cfg_delay_timer #(
    parameter int DELAY_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int W = $clog2(DELAY_CYCLES + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(DELAY_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ov7670_cfg_seq.sv
// Walks the OV7670 init ROM from address 0 and issues one SCCB write per entry,
// honouring the delay/end control words and retrying NACKed writes.
module ov7670_cfg_seq
    import ov7670_pkg::*;
#(
    parameter int DELAY_CYCLES = 1_000_000,
    parameter int MAX_RETRY    = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    output logic [7:0]              rom_addr,
    input  logic [15:0]             rom_data,
    ov7670_cfg_seq_if.master        sccb,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [7:0]              wr_count
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    cfg_state_t  state, state_nx;
    cfg_entry_t  entry, entry_nx;
    logic [7:0]  rom_addr_nx, wr_count_nx;
    logic [7:0]  reg_q, reg_nx, data_q, data_nx;
    logic        valid_q, valid_nx;
    logic        busy_nx, done_nx, error_nx;
    logic [RW-1:0] retry, retry_nx;
    logic        timer_load, timer_dec, timer_zero;
    logic        advance;

    cfg_delay_timer #(
        .DELAY_CYCLES(DELAY_CYCLES)
    ) u_delay (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (timer_load),
        .dec    (timer_dec),
        .zero   (timer_zero)
    );

    // Every output is a register so the SCCB master and camera top see clean levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            entry    <= '0;
            rom_addr <= '0;
            wr_count <= '0;
            reg_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            retry    <= '0;
        end else begin
            state    <= state_nx;
            entry    <= entry_nx;
            rom_addr <= rom_addr_nx;
            wr_count <= wr_count_nx;
            reg_q    <= reg_nx;
            data_q   <= data_nx;
            valid_q  <= valid_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            error    <= error_nx;
            retry    <= retry_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        entry_nx    = entry;
        rom_addr_nx = rom_addr;
        wr_count_nx = wr_count;
        reg_nx      = reg_q;
        data_nx     = data_q;
        valid_nx    = valid_q;
        busy_nx     = busy;
        done_nx     = done;
        error_nx    = error;
        retry_nx    = retry;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;
        advance     = 1'b0;

        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    rom_addr_nx = '0;
                    wr_count_nx = '0;
                    retry_nx    = '0;
                    done_nx     = 1'b0;
                    error_nx    = 1'b0;
                    busy_nx     = 1'b1;
                    state_nx    = FETCH;
                end
            end
            FETCH: state_nx = LATCH;
            LATCH: begin
                entry_nx = cfg_entry_t'(rom_data);
                state_nx = DECODE;
            end
            DECODE: begin
                if (entry == ROM_END) begin
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end else if (entry == ROM_DELAY) begin
                    timer_load = 1'b1;
                    state_nx   = DELAY;
                end else begin
                    reg_nx   = entry.reg_addr;
                    data_nx  = entry.value;
                    valid_nx = 1'b1;
                    state_nx = SEND;
                end
            end
            // A done pulse coinciding with the handshake is never looked at here.
            SEND: begin
                if (sccb.sccb_ready) begin
                    valid_nx = 1'b0;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (sccb.sccb_done) begin
                    if (!sccb.sccb_nack) begin
                        wr_count_nx = (wr_count != 8'hFF) ? wr_count + 8'd1 : wr_count;
                        retry_nx    = '0;
                        advance     = 1'b1;
                    end else if (retry < RW'(MAX_RETRY)) begin
                        retry_nx = retry + RW'(1);
                        valid_nx = 1'b1;
                        state_nx = SEND;
                    end else begin
                        busy_nx  = 1'b0;
                        error_nx = 1'b1;
                        state_nx = ERR;
                    end
                end
            end
            DELAY: begin
                if (timer_zero) begin
                    advance = 1'b1;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // The last ROM address ends the run instead of wrapping to 0.
        if (advance) begin
            if (rom_addr == 8'hFF) begin
                busy_nx  = 1'b0;
                done_nx  = 1'b1;
                state_nx = DONE;
            end else begin
                rom_addr_nx = rom_addr + 8'd1;
                state_nx    = FETCH;
            end
        end
    end

    assign sccb.sccb_valid = valid_q;
    assign sccb.sccb_reg   = reg_q;
    assign sccb.sccb_data  = data_q;

endmodule

// File: doc/ov7670_cfg_seq.md
Name: ov7670_cfg_seq

Overview:
Sequencer that walks the OV7670 register-init ROM from address 0 and turns each 16-bit entry {reg, value} into an SCCB write request to the SCCB master. It interprets the two ROM control codes: 16'hFFF0 means timed delay, 16'hFFFF means end of table. It sits between the camera-init ROM and the SCCB master, and reports busy/done/error to the top-level camera controller.

Parameters:
DELAY_CYCLES, 1_000_000, length of the FFF0 delay in clk cycles (10 ms at 100 MHz).
MAX_RETRY, 3, number of re-sends of one entry after an SCCB NACK before the block declares an error.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; starts the sequence from ROM address 0
rom_addr  out  8  ROM address (registered)
rom_data  in  16  ROM output; valid one cycle after rom_addr changes (registered ROM)
sccb_valid  out  1  write request to the SCCB master
sccb_ready  in  1  SCCB master accepts the request when valid && ready
sccb_reg  out  8  register address = entry[15:8]
sccb_data  out  8  register value = entry[7:0]
sccb_done  in  1  one-cycle pulse; the accepted transaction has finished
sccb_nack  in  1  qualified by sccb_done; the slave did not acknowledge
busy  out  1  high from the accepted start until DONE or ERR
done  out  1  level; the table completed successfully
error  out  1  level; retries were exhausted
wr_count  out  8  number of successful writes in the current run

Behaviour:
- Reset values: rom_addr=0, sccb_valid=0, sccb_reg=0, sccb_data=0, busy=0, done=0, error=0, wr_count=0, state=IDLE. Reset is honoured in any state; it drops sccb_valid immediately.
- All outputs are registered.
- States: IDLE, FETCH, LATCH, DECODE, SEND, WAIT, DELAY, DONE, ERR.
- IDLE / DONE / ERR + start: rom_addr←0, wr_count←0, retry←0, done←0, error←0, busy←1, then go to FETCH.
- start is ignored in all other states.
- FETCH: hold rom_addr for 1 cycle, then go to LATCH.
- LATCH: entry←rom_data, then go to DECODE.
- Start to the first sampled entry is 2 cycles.
- DECODE, checked in priority order:
  - entry==FFFF → DONE (busy←0, done←1).
  - entry==FFF0 → DELAY; load the counter with DELAY_CYCLES-1.
  - otherwise → SEND; sccb_reg/sccb_data←entry; sccb_valid←1.
- SEND: hold valid, reg and data stable until sccb_ready; on the handshake cycle valid←0, then go to WAIT. There is no timeout on ready.
- WAIT: wait for sccb_done. Ignore a sccb_done that arrives in the handshake cycle itself.
  - done && !nack → wr_count+1, retry←0, go to ADV.
  - done && nack && retry<MAX_RETRY → retry+1, back to SEND with the same entry.
  - done && nack && retry==MAX_RETRY → ERR (busy←0, error←1, rom_addr frozen at the failing entry).
- DELAY: count down to 0, then ADV. The delay occupies exactly DELAY_CYCLES cycles between DECODE and the next FETCH.
- ADV (action folded into the WAIT/DELAY exit):
  - rom_addr==255 → DONE; there is no wrap to 0.
  - otherwise rom_addr+1, go to FETCH.
- wr_count saturates at 255.
- The delay counter width is $clog2(DELAY_CYCLES+1). DELAY_CYCLES must be ≥ 1.
- done/error stay high until the next accepted start or reset.

Decomposition:
- Shared package ov7670_pkg holds:
  - the state enum cfg_state_t;
  - constants ROM_END=16'hFFFF and ROM_DELAY=16'hFFF0;
  - the entry typedef struct {logic [7:0] reg_addr; logic [7:0] value;}.
- One natural sub-module: cfg_delay_timer, a loadable down-counter with a zero flag parameterised by DELAY_CYCLES. Everything else stays in the FSM.

Test Plan:
- Behavioural ROM {0:1280, 1:FFF0, 2:1214, 3:FFFF}, DELAY_CYCLES=8, ready always 1, done 3 cycles after the handshake:
  - expect exactly 2 handshakes, (12,80) then (12,14);
  - expect 8 cycles between DECODE of addr 1 and rom_addr=2;
  - expect done=1, busy=0, wr_count=2.
- sccb_ready held low for 20 cycles on entry 0 → sccb_valid stays high with reg=12, data=80 stable throughout; exactly one handshake when ready rises.
- NACK on entry 0 twice, then ACK, MAX_RETRY=3 → 3 handshakes all with (12,80); wr_count=1; error=0.
- NACK 4 times on entry 2 → after the 4th done: error=1, busy=0, rom_addr=2, done=0. A new start then runs from address 0.
- reset_n asserted during DELAY and again during SEND → every output returns to its reset value at once (valid drops in the same cycle); after release a start runs cleanly.
- start pulsed while busy → no restart; rom_addr continues incrementing. A 256-entry ROM with no FFFF → DONE after address 255, rom_addr stays at 255.
